// File: rtl/shared_debounce_scheduler.sv
// shared_debounce_scheduler: N-channel button debouncer sharing one settle timer via a round-robin scheduler
module shared_debounce_scheduler #(
    parameter int N_CH        = 5,
    parameter int FINAL_VALUE = 1_999_999
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_CH-1:0]         noisy,
    output logic [N_CH-1:0]         debounced,
    output logic [N_CH-1:0]         rise_pulse,
    output logic [N_CH-1:0]         fall_pulse,
    output logic                    busy,
    output logic [$clog2(N_CH)-1:0] grant_ch
);
    localparam int GW = $clog2(N_CH);
    localparam int CW = $clog2(FINAL_VALUE + 1);
    localparam logic [CW-1:0] TERM = CW'(FINAL_VALUE);
    localparam logic [GW-1:0] LAST = GW'(N_CH - 1);

    typedef enum logic {IDLE, TIMING} state_t;

    state_t          state, state_next;
    logic [N_CH-1:0] sync1, sync2, req;
    logic [CW-1:0]   counter, counter_next;
    logic [GW-1:0]   rr_ptr, rr_next, grant_next, pick, rr_after;
    logic [N_CH-1:0] deb_next, rise_next, fall_next;
    logic            found;

    assign req      = sync2 ^ debounced;
    assign busy     = (state == TIMING);
    assign rr_after = (grant_ch == LAST) ? '0 : grant_ch + GW'(1);

    // two-flop synchronizer for the raw button levels
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= noisy;
            sync2 <= sync1;
        end
    end

    // round-robin search: first requester at or above rr_ptr, wrapping
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr;
        for (int k = 0; k < N_CH; k++) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    // scheduler next state: grant from IDLE, count/abort/complete in TIMING
    always_comb begin
        state_next   = state;
        counter_next = counter;
        grant_next   = grant_ch;
        rr_next      = rr_ptr;
        deb_next     = debounced;
        rise_next    = '0;
        fall_next    = '0;
        if (state == IDLE) begin
            if (found) begin
                state_next   = TIMING;
                grant_next   = pick;
                counter_next = '0;
            end
        end else if (!req[grant_ch]) begin
            state_next = IDLE;
            rr_next    = rr_after;
        end else if (counter == TERM) begin
            state_next          = IDLE;
            rr_next             = rr_after;
            deb_next[grant_ch]  = ~debounced[grant_ch];
            rise_next[grant_ch] = ~debounced[grant_ch];
            fall_next[grant_ch] = debounced[grant_ch];
        end else begin
            counter_next = counter + CW'(1);
        end
    end

    // scheduler state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // timer, grant, pointer and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter    <= '0;
            grant_ch   <= '0;
            rr_ptr     <= '0;
            debounced  <= '0;
            rise_pulse <= '0;
            fall_pulse <= '0;
        end else begin
            counter    <= counter_next;
            grant_ch   <= grant_next;
            rr_ptr     <= rr_next;
            debounced  <= deb_next;
            rise_pulse <= rise_next;
            fall_pulse <= fall_next;
        end
    end
endmodule

// File: tb/tb_shared_debounce_scheduler.sv
// tb_shared_debounce_scheduler: directed and random checks of the shared debounce scheduler
module tb_shared_debounce_scheduler;
    localparam int N  = 5;
    localparam int FV = 9;
    localparam int BOUND = (N - 1) * (FV + 2);

    logic         clk;
    logic         reset_n;
    logic [N-1:0] noisy;
    logic [N-1:0] debounced, rise_pulse, fall_pulse;
    logic         busy;
    logic [2:0]   grant_ch;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] m_s1, m_s2, prev_s2, prev_deb, pulses, chg;
    int stab [N];
    int wait_c [N];
    int max_wait;
    int changes;

    shared_debounce_scheduler #(.N_CH(N), .FINAL_VALUE(FV)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .noisy(noisy),
        .debounced(debounced),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .busy(busy),
        .grant_ch(grant_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference synchronizer used to judge input stability
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_s1 <= '0;
            m_s2 <= '0;
        end else begin
            m_s1 <= noisy;
            m_s2 <= m_s1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        noisy   = '1;
        reset_n = 1'b0;
        #1;
        check("rst_deb", debounced, 0);
        check("rst_pulses", rise_pulse | fall_pulse, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_ch, 0);
        tick(3);
        check("rst_sync_held", dut.sync2, 0);
        check("rst_deb_clk", debounced, 0);
        noisy   = '0;
        reset_n = 1'b1;

        // single channel rise: change lands on the 13th edge
        noisy = 5'b00001;
        tick(2);
        check("a_idle_e2", busy, 0);
        tick(1);
        check("a_busy_e3", busy, 1);
        check("a_grant_e3", grant_ch, 0);
        check("a_cnt_e3", dut.counter, 0);
        tick(9);
        check("a_deb_e12", debounced, 0);
        check("a_cnt_e12", dut.counter, 9);
        tick(1);
        check("a_deb_e13", debounced, 5'b00001);
        check("a_rise_e13", rise_pulse, 5'b00001);
        check("a_busy_e13", busy, 0);
        check("a_rr", dut.rr_ptr, 1);
        tick(1);
        check("a_rise_done", rise_pulse, 0);

        // channel 1 glitch of 6 cycles aborts
        noisy = 5'b00011;
        tick(3);
        check("b_busy", busy, 1);
        check("b_grant", grant_ch, 1);
        tick(3);
        check("b_busy_e6", busy, 1);
        noisy = 5'b00001;
        tick(3);
        check("b_abort", busy, 0);
        check("b_deb", debounced, 5'b00001);
        check("b_pulses", rise_pulse | fall_pulse, 0);
        check("b_rr", dut.rr_ptr, 2);

        // channel 3 rises
        noisy = 5'b01001;
        tick(3);
        check("c_grant", grant_ch, 3);
        tick(10);
        check("c_deb", debounced, 5'b01001);
        check("c_rise", rise_pulse, 5'b01000);

        // channel 3 falls
        noisy = 5'b00001;
        tick(13);
        check("d_deb", debounced, 5'b00001);
        check("d_fall", fall_pulse, 5'b01000);
        check("d_norise", rise_pulse, 0);
        tick(1);
        check("d_fall_done", fall_pulse, 0);

        // channel 0 falls (rr 4 -> grant 0), then channel 4 abort steers rr to 0
        noisy = 5'b00000;
        tick(13);
        check("e_pre_deb", debounced, 0);
        check("e_pre_fall", fall_pulse, 5'b00001);
        noisy = 5'b10000;
        tick(3);
        check("e_pre_grant4", grant_ch, 4);
        tick(3);
        noisy = 5'b00000;
        tick(3);
        check("e_pre_idle", busy, 0);
        check("e_pre_rr", dut.rr_ptr, 0);

        // channels 0 and 2 together: 0 first, 2 eleven cycles later
        noisy = 5'b00101;
        tick(12);
        check("e_deb_e12", debounced, 0);
        tick(1);
        check("e_deb0", debounced, 5'b00001);
        check("e_rise0", rise_pulse, 5'b00001);
        check("e_idle_gap", busy, 0);
        tick(1);
        check("e_busy2", busy, 1);
        check("e_grant2", grant_ch, 2);
        tick(9);
        check("e_deb_e23", debounced, 5'b00001);
        tick(1);
        check("e_deb2", debounced, 5'b00101);
        check("e_rise2", rise_pulse, 5'b00100);
        check("e_rr", dut.rr_ptr, 3);

        // reset in the middle of a settle
        noisy = 5'b00111;
        tick(8);
        check("f_cnt5", dut.counter, 5);
        check("f_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check("f_rst_deb", debounced, 0);
        check("f_rst_busy", busy, 0);
        check("f_rst_pulses", rise_pulse | fall_pulse, 0);
        check("f_rst_cnt", dut.counter, 0);
        check("f_rst_rr", dut.rr_ptr, 0);
        tick(2);
        reset_n = 1'b1;
        tick(2);
        check("f_idle_e2", busy, 0);
        tick(1);
        check("f_grant_e3", grant_ch, 0);
        tick(9);
        check("f_deb_e12", debounced, 0);
        tick(1);
        check("f_deb_e13", debounced, 5'b00001);
        check("f_rise_e13", rise_pulse, 5'b00001);
        tick(30);
        check("f_settled", debounced, 5'b00111);

        // random toggling with property checks
        prev_deb = debounced;
        prev_s2  = m_s2;
        max_wait = 0;
        changes  = 0;
        for (int i = 0; i < N; i++) begin
            stab[i]   = 100;
            wait_c[i] = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(31) == 0) noisy[i] = ~noisy[i];
            tick(1);
            pulses = rise_pulse | fall_pulse;
            chg    = debounced ^ prev_deb;
            check("r_onehot", $countones(pulses) <= 1, 1);
            check("r_pulse_vs_change", pulses, chg);
            check("r_rise_dir", rise_pulse, chg & debounced);
            for (int i = 0; i < N; i++) begin
                if (chg[i]) begin
                    check("r_stable_before", stab[i] >= FV + 1, 1);
                    check("r_new_level", debounced[i], prev_s2[i]);
                    changes++;
                end
                stab[i] = (m_s2[i] == prev_s2[i]) ? stab[i] + 1 : 1;
                if ((m_s2[i] ^ debounced[i]) && !(busy && grant_ch == i)) wait_c[i]++;
                else wait_c[i] = 0;
                if (wait_c[i] > max_wait) max_wait = wait_c[i];
            end
            prev_s2  = m_s2;
            prev_deb = debounced;
        end
        check("r_max_wait", max_wait <= BOUND, 1);
        check("r_activity", changes > 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shared_debounce_scheduler.md
SHARED_DEBOUNCE_SCHEDULER -- requirements
Module: shared_debounce_scheduler

Interface
REQ-001 The block SHALL have parameter N_CH, default 5, giving the number of button channels (legal range 2..8).
REQ-002 The block SHALL have parameter FINAL_VALUE, default 1_999_999, giving the terminal count of the shared settle timer (minimum 1); at 100 MHz the default gives 20 ms.
REQ-003 The block SHALL have input clk, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have input reset_n, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have input noisy, N_CH bits: raw asynchronous button levels; bit i belongs to channel i.
REQ-006 The block SHALL have output debounced, N_CH bits: debounced level per channel, registered.
REQ-007 The block SHALL have output rise_pulse, N_CH bits: one-cycle pulse on a 0->1 debounced transition, registered.
REQ-008 The block SHALL have output fall_pulse, N_CH bits: one-cycle pulse on a 1->0 debounced transition, registered.
REQ-009 The block SHALL have output busy, 1 bit: high while the shared timer is granted to a channel.
REQ-010 The block SHALL have output grant_ch, $clog2(N_CH) bits: index of the granted channel, valid only while busy=1.

Function
REQ-011 Each noisy bit SHALL pass through a 2-flop synchronizer; sync[i] denotes the second-stage output.
REQ-012 Channel i SHALL request the timer when req[i] = sync[i] XOR debounced[i] is 1.
REQ-013 A single counter of width $clog2(FINAL_VALUE+1) SHALL serve as the shared settle timer; there are no per-channel timers.
REQ-014 The scheduler SHALL be an FSM with exactly two states, IDLE and TIMING.
REQ-015 In IDLE with any req set, the FSM SHALL grant the first requesting index found searching upward from rr_ptr with wrap-around, register it into grant_ch, clear the counter to 0, and enter TIMING on the next edge.
REQ-016 In IDLE with no req set, the FSM SHALL stay in IDLE, and the counter and grant_ch SHALL hold.
REQ-017 In TIMING the counter SHALL increment by 1 per cycle from 0 while req[grant_ch]=1.
REQ-018 In TIMING, if req[grant_ch]=0 in any cycle, including the terminal cycle, the FSM SHALL abort: return to IDLE, set rr_ptr to (grant_ch+1) mod N_CH, and leave debounced unchanged.
REQ-019 In TIMING, when counter==FINAL_VALUE and req[grant_ch]=1, the FSM SHALL on the next edge toggle debounced[grant_ch], pulse the matching rise_pulse or fall_pulse bit for exactly one cycle, set rr_ptr to (grant_ch+1) mod N_CH, and return to IDLE.
REQ-020 For an uncontested channel whose noisy input is stable, debounced SHALL change exactly FINAL_VALUE+4 rising edges after the first edge that samples the new noisy level.
REQ-021 Requests from non-granted channels SHALL wait; a changed input SHALL never be lost while req persists, and a channel whose input reverts before its grant SHALL simply drop its request.
REQ-022 The worst-case wait before a grant SHALL be bounded by (N_CH-1)*(FINAL_VALUE+2) cycles.
REQ-023 At most one bit of rise_pulse|fall_pulse SHALL be high in any cycle, and every such pulse SHALL coincide with the debounced update of the same channel.
REQ-024 busy SHALL equal (state==TIMING); grant_ch SHALL hold its value for the whole TIMING interval.
REQ-025 The terminal-cycle decision and the arbitration of the next grant SHALL never occur in the same cycle; IDLE always lasts at least one cycle between grants.
REQ-026 rr_ptr SHALL be $clog2(N_CH) bits wide and wrap from N_CH-1 to 0; it never takes a value of N_CH or above.

Reset
REQ-027 While reset_n=0, the synchronizer flops, debounced, rise_pulse, fall_pulse, counter, grant_ch and rr_ptr SHALL all be 0, and state SHALL be IDLE (busy=0), independent of clk.
REQ-028 A reset asserted during TIMING SHALL discard the in-progress settle with no pulse; after release, any channel with noisy=1 SHALL re-request from IDLE.

Verification (FINAL_VALUE=9, N_CH=5)
REQ-029 The bench SHALL drive noisy[0] 0->1 and hold it, with other channels idle -> debounced[0]=1 and rise_pulse[0]=1 for one cycle, exactly 13 edges after the first sampling edge.
REQ-030 The bench SHALL drive noisy[1]=1 for 6 cycles and then return it to 0 -> busy rises then drops (abort), debounced[1] stays 0, no pulse, and rr_ptr=2.
REQ-031 The bench SHALL drive noisy[0] and noisy[2] 0->1 on the same edge with rr_ptr=0 -> channel 0 is debounced first; channel 2 is granted after one IDLE cycle and updates 11 cycles after channel 0.
REQ-032 With debounced[3]=1, the bench SHALL drive noisy[3] 1->0 -> debounced[3]=0 and fall_pulse[3] pulses once, with no rise_pulse.
REQ-033 The bench SHALL assert reset_n=0 at counter=5 of a TIMING interval -> all outputs are 0 immediately; after release with noisy held at 1, the full 13-edge settle restarts.
REQ-034 The bench SHALL toggle all 5 inputs randomly for 10k cycles -> the pulse one-hot property holds, each debounced bit changes only after ≥10 stable synchronized cycles, and no request starves beyond the REQ-022 bound.
